// File: rtl/seq_addsub_ctrl_pkg.sv
// Shared constants and types for the digit-serial add/subtract sequencer.
package addsub_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/seq_addsub_ctrl_if.sv
// Operand-side and result-side valid/ready bundle of the add/subtract sequencer.
interface seq_addsub_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             inValid;
  logic             inReady;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             v;

  modport master (
    output inValid, sub, cin, x, y, outReady,
    input  inReady, outValid, result, cout, v
  );

  modport slave (
    input  inValid, sub, cin, x, y, outReady,
    output inReady, outValid, result, cout, v
  );
endinterface

// File: rtl/seq_addsub_ctrl_cla.sv
// 4-bit carry-lookahead adder-subtractor slice; sub inverts b and forces carry-in to 1.
module claAddSub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       v
);
  logic [3:0] bx;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    bx   = b ^ {4{sub}};
    g    = a & bx;
    p    = a ^ bx;
    c[0] = sub | cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c[3:0];
    cout = c[4];
    v    = c[4] ^ c[3];
  end
endmodule

// File: rtl/seq_addsub_ctrl.sv
// WIDTH-bit add/subtract run LSB-digit-first through one shared 4-bit CLA slice,
// with the inter-digit carry held in carry_q.
module seq_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  seq_addsub_ctrl_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("seq_addsub_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  seq_state_t       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;

  logic [SLICE_W-1:0] x_digs [NSLICE];
  logic [SLICE_W-1:0] y_digs [NSLICE];
  logic [SLICE_W-1:0] x_dig, y_dig, s_dig;
  logic               s_cout, s_v;

  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_digits
    assign x_digs[gi] = x_q[gi*SLICE_W +: SLICE_W];
    assign y_digs[gi] = y_q[gi*SLICE_W +: SLICE_W];
  end

  // Slice sub stays 0: its forced carry-in would break chaining, so the
  // inversion is done here and the +1 rides in through carry_q.
  claAddSub4 u_slice (
    .a    (x_dig),
    .b    (y_dig ^ {SLICE_W{sub_q}}),
    .sub  (1'b0),
    .cin  (carry_q),
    .s    (s_dig),
    .cout (s_cout),
    .v    (s_v)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      k_q      <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      v_q      <= v_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    cout_d   = cout_q;
    v_d      = v_q;
    x_dig    = '0;
    y_dig    = '0;

    for (int i = 0; i < NSLICE; i++) begin
      if (k_q == KW'(i)) begin
        x_dig = x_digs[i];
        y_dig = y_digs[i];
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.inValid) begin
          x_d     = bus.x;
          y_d     = bus.y;
          sub_d   = bus.sub;
          carry_d = bus.sub | bus.cin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (k_q == KW'(i)) begin
            result_d[i*SLICE_W +: SLICE_W] = s_dig;
          end
        end
        carry_d = s_cout;
        k_d     = k_q + 1'b1;
        if (k_q == KW'(NSLICE - 1)) begin
          cout_d  = s_cout;
          v_d     = s_v;
          k_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.outReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.inReady  = (state_q == IDLE);
  assign bus.outValid = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.v        = v_q;
endmodule
